register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  General-purpose register file for the 8-bit datapath: 8 x 8-bit registers.
//  Two asynchronous read ports, one synchronous write port.
//  Written on every rising clock edge; there is no write-enable.
//  Sits between instruction decode (register addresses) and ALU/writeback (data).
// PARAMETERS
//  DATA_W  8  register width in bits
//  ADDR_W  3  address width in bits
//  DEPTH   2**ADDR_W (8)  number of registers; derived, do not override
// PORTS (positional order is fixed; instantiated by position)
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       reset; synchronous, active-low
//  ReadReg1   in   ADDR_W  read port 1 address
//  ReadReg2   in   ADDR_W  read port 2 address
//  WriteReg   in   ADDR_W  write address
//  WriteData  in   DATA_W  write data
//  ReadData1  out  DATA_W  contents of register ReadReg1
//  ReadData2  out  DATA_W  contents of register ReadReg2
// BEHAVIOUR
//  - Storage: regs[0..DEPTH-1], each DATA_W bits. Register 0 is an ordinary
//    writable register (not hardwired to zero).
//  - Reset: on a rising clk edge with rst==0, every register is cleared to 0.
//    Reset takes priority over the write, so no write occurs on that edge.
//    Mid-operation reset behaves the same: all prior contents are lost.
//  - Write: on a rising clk edge with rst==1, regs[WriteReg] <= WriteData.
//    This happens unconditionally every cycle.
//    X/Z on WriteData is stored as-is. Callers must drive valid data.
//  - Read: combinational, zero latency.
//    ReadDataN = regs[ReadRegN], valid in the same cycle the address changes.
//  - The two read ports are independent. Both may address the same register.
//  - Read-during-write to the same address, macro undefined:
//    the read returns the OLD value until the clock edge and the NEW value after it.
//  - Before the first reset, register contents are undefined (X in simulation).
//  - Address width exactly covers DEPTH, so there are no out-of-range addresses.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    when rst==1 and ReadRegN==WriteReg, ReadDataN = WriteData combinationally
//    (write-through forwarding). This is independent per read port.
//    When rst==0, no forwarding; reads return stored contents.
//  REGFILE_BYPASS_EN undefined:
//    pure array read, per the read-during-write rule above.
// TESTING
//  1. rst=0 for one edge, then hold addresses -> ReadData1=ReadData2=0
//     for all 8 addresses.
//  2. rst=1, WriteReg=0, WriteData=10, one edge; then ReadReg1=0
//     -> ReadData1=10.
//  3. Sequence WriteReg=k, WriteData=k for k=1..7, reading ReadReg1=k-1 and
//     ReadReg2=k in the same cycle -> ReadData1=k-1 (reg 0 gives 10).
//     ReadData2=0 before the edge and k after it (macro undefined), or k
//     immediately (macro defined).
//  4. After step 3, ReadReg1=6, ReadReg2=0 -> 6 and 10.
//     Both ports on address 5 -> 5 and 5.
//  5. Write 8'hFF to reg 3, then assert rst=0 for one edge with
//     WriteReg=3, WriteData=8'hAA -> reg 3 reads 0 (reset beats write).
//  6. Write 8'h55 to reg 7, then wiggle only rst between edges (no edge)
//     -> still 8'h55. This confirms reset is synchronous.

Source files
------------

// File: rtl/register_file.sv
// register_file: 8 x 8-bit general-purpose register file for the 8-bit datapath.
// Two combinational read ports and one synchronous write port. There is no
// write enable, so WriteReg is written on every rising clock edge unless reset
// is asserted.
// Reset is synchronous and active-low. It clears every register and takes
// priority over the write on the same edge.
// Optional feature: define REGFILE_BYPASS_EN to forward WriteData to a read
// port in the same cycle when that port addresses WriteReg and reset is
// deasserted. Without the macro, reads return the stored value, so a
// same-cycle read of WriteReg sees the old contents until the edge.
module register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  // Derived from the address width; the address exactly covers the array.
  localparam int DEPTH = 2 ** ADDR_W;

  // Register 0 is an ordinary writable register, not a hardwired zero.
  logic [DATA_W-1:0] regs [DEPTH];

  // Raw array reads, before any forwarding is applied.
  logic [DATA_W-1:0] arrayData1;
  logic [DATA_W-1:0] arrayData2;

  // Storage update: a synchronous clear wins over the unconditional write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Zero-latency array lookup for both independent read ports.
  always_comb begin
    arrayData1 = regs[ReadReg1];
    arrayData2 = regs[ReadReg2];
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding, decided separately for each port; it is
  // suppressed during reset because that edge performs no write.
  logic hit1;
  logic hit2;

  always_comb begin
    hit1      = rst && (ReadReg1 == WriteReg);
    hit2      = rst && (ReadReg2 == WriteReg);
    ReadData1 = hit1 ? WriteData : arrayData1;
    ReadData2 = hit2 ? WriteData : arrayData2;
  end
`else
  // Pure array read: a same-cycle read of WriteReg sees the old value
  // until the edge and the new value after it.
  always_comb begin
    ReadData1 = arrayData1;
    ReadData2 = arrayData2;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file, with a short randomised write/read phase
// at the end. Expected values go into exp_q when stimulus is driven and are
// popped when the read ports are sampled. Inputs change on the falling edge,
// and outputs are sampled between edges.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic [2:0] ReadReg1;
  logic [2:0] ReadReg2;
  logic [2:0] WriteReg;
  logic [7:0] WriteData;
  logic [7:0] ReadData1;
  logic [7:0] ReadData2;

  logic [7:0] exp_q[$];
  int         vectors;
  int         miscompares;

  // Bench-side model of the register contents, used by the random phase.
  logic [7:0] mdl [8];

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  // Clock: 10-time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update from the driven inputs only.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    end else begin
      mdl[WriteReg] = WriteData;
    end
  end

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra1, input logic [2:0] ra2);
    rst       = r;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = ra1;
    ReadReg2  = ra2;
  endtask

  initial begin
    logic [2:0] wa, ra1, ra2;
    logic [7:0] wd, e1, e2;
    vectors     = 0;
    miscompares = 0;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);

    // Step 1: reset state. rst stays low, so every register reads 0.
    @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a);
      ReadReg2 = 3'(7 - a);
      push_exp(8'h00);
      push_exp(8'h00);
      #1;
      check($sformatf("reset_rd1_a%0d", a), ReadData1);
      check($sformatf("reset_rd2_a%0d", 7 - a), ReadData2);
    end

    // Step 2: write 10 into register 0 and read it back.
    @(negedge clk);
    drive(1'b1, 3'd0, 8'd10, 3'd0, 3'd1);
    @(posedge clk);
    #1;
    push_exp(8'd10);
    check("reg0_write", ReadData1);

    // Step 3: write k into register k. Port 1 reads the previous register,
    // and port 2 reads register k both before and after the edge.
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      drive(1'b1, 3'(k), 8'(k), 3'(k - 1), 3'(k));
      push_exp((k == 1) ? 8'd10 : 8'(k - 1));
`ifdef REGFILE_BYPASS_EN
      push_exp(8'(k));
`else
      push_exp(8'h00);
`endif
      push_exp(8'(k));
      #1;
      check($sformatf("seq_rd1_k%0d", k), ReadData1);
      check($sformatf("seq_rd2_pre_k%0d", k), ReadData2);
      @(posedge clk);
      #1;
      check($sformatf("seq_rd2_post_k%0d", k), ReadData2);
    end

    // Step 4: two different registers, then both ports on one register.
    @(negedge clk);
    ReadReg1 = 3'd6;
    ReadReg2 = 3'd0;
    push_exp(8'd6);
    push_exp(8'd10);
    #1;
    check("dual_rd1_r6", ReadData1);
    check("dual_rd2_r0", ReadData2);
    ReadReg1 = 3'd5;
    ReadReg2 = 3'd5;
    push_exp(8'd5);
    push_exp(8'd5);
    #1;
    check("same_rd1_r5", ReadData1);
    check("same_rd2_r5", ReadData2);

    // Step 5: write FF to reg 3, then reset on an edge that also writes AA.
    // The reset wins, and the clear also wipes reg 5.
    @(negedge clk);
    drive(1'b1, 3'd3, 8'hFF, 3'd3, 3'd5);
    @(posedge clk);
    #1;
    push_exp(8'hFF);
    check("pre_reset_r3", ReadData1);
    @(negedge clk);
    drive(1'b0, 3'd3, 8'hAA, 3'd3, 3'd5);
    @(posedge clk);
    #1;
    push_exp(8'h00);
    push_exp(8'h00);
    check("reset_beats_write_r3", ReadData1);
    check("reset_clears_r5", ReadData2);

    // Step 6: write 55 to reg 7, then toggle rst between edges.
    // The register must keep its value because reset is synchronous.
    @(negedge clk);
    drive(1'b1, 3'd7, 8'h55, 3'd7, 3'd7);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    push_exp(8'h55);
    check("rst_low_no_edge_r7", ReadData1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    push_exp(8'h55);
    push_exp(8'h55);
    #0.5;
    check("rst_wiggle_rd1_r7", ReadData1);
    check("rst_wiggle_rd2_r7", ReadData2);

    // Random phase: random writes and reads, checked against the model
    // before and after each edge.
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      wa  = 3'($urandom_range(0, 7));
      wd  = 8'($urandom_range(0, 255));
      ra1 = 3'($urandom_range(0, 7));
      ra2 = (n % 4 == 0) ? wa : 3'($urandom_range(0, 7));
      drive(1'b1, wa, wd, ra1, ra2);
`ifdef REGFILE_BYPASS_EN
      e1 = (ra1 == wa) ? wd : mdl[ra1];
      e2 = (ra2 == wa) ? wd : mdl[ra2];
`else
      e1 = mdl[ra1];
      e2 = mdl[ra2];
`endif
      push_exp(e1);
      push_exp(e2);
      #1;
      check($sformatf("rand_pre_rd1_%0d", n), ReadData1);
      check($sformatf("rand_pre_rd2_%0d", n), ReadData2);
      @(posedge clk);
      #1;
      push_exp(mdl[ra1]);
      push_exp(mdl[ra2]);
      check($sformatf("rand_post_rd1_%0d", n), ReadData1);
      check($sformatf("rand_post_rd2_%0d", n), ReadData2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
